xgs_spi_arbiter: RTL and testbench
==================================

XGS_SPI_ARBITER -- requirements
Module: xgs_spi_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, sensor register address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, sensor register data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 4096, the maximum number of WAIT cycles before abort.
REQ-004 The block SHALL have parameter MAX_HOST_SKIP, default 4, the host starvation limit.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port sys_reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port host_req, input, 1 bit: host register access request.
REQ-008 The block SHALL have port host_wr, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have ports host_addr (input, ADDR_W) and host_wdata (input, DATA_W): host access fields.
REQ-010 The block SHALL have ports host_ack (output, 1), host_done (output, 1), host_rdata (output, DATA_W) and host_err (output, 1): host responses.
REQ-011 The block SHALL have ports seq_req, seq_wr, seq_addr, seq_wdata, seq_ack, seq_done, seq_rdata and seq_err: the grab-sequencer requester, with the same widths and directions as the host_ group.
REQ-012 The block SHALL have port grab_active, input, 1 bit: 1 = a grab is in progress (sequencer-priority mode).
REQ-013 The block SHALL have ports spi_start (output, 1), spi_wr (output, 1), spi_addr (output, ADDR_W) and spi_wdata (output, DATA_W): SPI master command.
REQ-014 The block SHALL have ports spi_busy (input, 1), spi_done (input, 1) and spi_rdata (input, DATA_W): SPI master status.
REQ-015 The block SHALL have port owner, output, 1 bit: 0 = host, 1 = seq; the current or last grantee.
REQ-016 The block SHALL have port timeout_cnt, output, 8 bits: saturating count of aborted transactions.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-018 In IDLE, when any req = 1 and spi_busy = 0, the block SHALL select a winner, latch its wr/addr/wdata into spi_* registers, update owner, and go to ISSUE; otherwise it SHALL remain in IDLE.
REQ-019 In ISSUE, the block SHALL drive spi_start = 1 and the winner's ack = 1 for exactly one cycle, clear the timer, and go to WAIT.
REQ-020 In WAIT, the timer SHALL increment every cycle; spi_done = 1 SHALL capture spi_rdata and move to RESP with err = 0.
REQ-021 In WAIT, when the timer reaches TIMEOUT-1 with spi_done = 0, the block SHALL move to RESP with err = 1 and increment timeout_cnt, saturating at 255.
REQ-022 If spi_done = 1 in the same cycle the timer reaches TIMEOUT-1, the block SHALL treat it as completion, not timeout.
REQ-023 In RESP, the block SHALL pulse the owner's done for one cycle, drive rdata (captured data for a completed read, 0 for a write or a timeout) and err, then return to IDLE.
REQ-024 rdata and err SHALL hold their values until the next RESP of the same requester.
REQ-025 Requesters SHALL hold req and fields stable until ack and deassert req at the edge that samples ack; req is sampled only in IDLE.
REQ-026 spi_done SHALL be ignored outside WAIT.
REQ-027 Latency from req sampled in IDLE to spi_start SHALL be 1 cycle; the minimum IDLE-to-IDLE transaction time SHALL be 4 cycles when spi_done arrives in the first WAIT cycle.
REQ-028 When grab_active = 0 and both requesters request, the block SHALL grant round-robin to the requester that is not last_owner.
REQ-029 When grab_active = 1, the block SHALL grant seq over host, except that once the host has lost MAX_HOST_SKIP consecutive contested grants, the host SHALL win the next contested grant.
REQ-030 The skip counter SHALL clear on any host grant and on grab_active = 0.
REQ-031 A single requester with no contention SHALL be granted in both modes.

Reset
REQ-032 While sys_reset = 1, the block SHALL go to IDLE, drive all outputs to 0, clear the timer and skip counter, and set last_owner = seq so the host wins the first tie.
REQ-033 When reset is asserted mid-transaction, no done pulse SHALL be issued for the aborted transaction, and a late spi_done after reset SHALL be ignored.

Verification
REQ-034 The bench SHALL cover a host read at addr 0x0A5, spi_done after 3 WAIT cycles with spi_rdata = 0x1234: spi_start 1 cycle after req, host_ack with spi_start, host_done with host_rdata = 0x1234 and host_err = 0.
REQ-035 The bench SHALL cover simultaneous host and seq writes with grab_active = 0 after reset: host granted first, then seq; owner sequence 0, 1.
REQ-036 The bench SHALL cover grab_active = 1 with both requesters continuously requesting: seq is granted 4 times, then host once, then the pattern repeats.
REQ-037 The bench SHALL cover a transaction where spi_done never arrives with TIMEOUT = 16: done with err = 1 and rdata = 0 after 16 WAIT cycles, and timeout_cnt increments to 1.
REQ-038 The bench SHALL cover spi_busy = 1 while a req is pending: no grant; the grant occurs the cycle after spi_busy falls.
REQ-039 The bench SHALL cover reset asserted in WAIT followed by spi_done 2 cycles later: no done pulse, state IDLE, and all outputs 0.

Source files
------------

// File: rtl/xgs_spi_arbiter.sv
// xgs_spi_arbiter: shares one SPI master between the host and the grab sequencer.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESP. When both requesters ask at
// once, the grant alternates between them. While a grab is running the sequencer
// wins instead, but the host is not starved: it takes the next contested grant
// after MAX_HOST_SKIP consecutive losses.
//
// Ports:
//   sys_clk, sys_reset        clock and synchronous active-high reset
//   host_* / seq_*            requester side: req/wr/addr/wdata in;
//                             ack/done/rdata/err out
//   grab_active               1 = sequencer-priority mode
//   spi_start/wr/addr/wdata   command to the SPI master (registered)
//   spi_busy/done/rdata       status from the SPI master
//   owner                     current or last grantee (0 = host, 1 = seq)
//   timeout_cnt               saturating count of aborted transactions
module xgs_spi_arbiter #(
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned TIMEOUT       = 4096,
  parameter int unsigned MAX_HOST_SKIP = 4
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  input  logic              seq_req,
  input  logic              seq_wr,
  input  logic [ADDR_W-1:0] seq_addr,
  input  logic [DATA_W-1:0] seq_wdata,
  output logic              seq_ack,
  output logic              seq_done,
  output logic [DATA_W-1:0] seq_rdata,
  output logic              seq_err,
  input  logic              grab_active,
  output logic              spi_start,
  output logic              spi_wr,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [DATA_W-1:0] spi_wdata,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rdata,
  output logic              owner,
  output logic [7:0]        timeout_cnt
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SkipW  = (MAX_HOST_SKIP > 0) ? $clog2(MAX_HOST_SKIP + 1) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [SkipW-1:0]  SkipLimit = SkipW'(MAX_HOST_SKIP);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q;
  logic                last_owner_q;
  logic [TimerW-1:0]   timer_q;
  logic [SkipW-1:0]    skip_q;

  logic                contested;
  logic                grant_seq;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_data;

  assign contested = host_req & seq_req;

  // Winner selection; only acted upon in IDLE.
  always_comb begin
    grant_seq = seq_req;
    if (contested) begin
      if (grab_active) begin
        grant_seq = (skip_q < SkipLimit);
      end else begin
        grant_seq = ~last_owner_q;
      end
    end
  end

  // Completion wins over a timeout landing in the same cycle; writes and
  // aborts return zero data.
  assign rsp_err  = ~spi_done;
  assign rsp_data = (spi_done && !spi_wr) ? spi_rdata : '0;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;  // host wins the first tie
      timer_q      <= '0;
      skip_q       <= '0;
      host_ack     <= 1'b0;
      host_done    <= 1'b0;
      host_rdata   <= '0;
      host_err     <= 1'b0;
      seq_ack      <= 1'b0;
      seq_done     <= 1'b0;
      seq_rdata    <= '0;
      seq_err      <= 1'b0;
      spi_start    <= 1'b0;
      spi_wr       <= 1'b0;
      spi_addr     <= '0;
      spi_wdata    <= '0;
      owner        <= 1'b0;
      timeout_cnt  <= '0;
    end else begin
      host_ack  <= 1'b0;
      seq_ack   <= 1'b0;
      spi_start <= 1'b0;
      host_done <= 1'b0;
      seq_done  <= 1'b0;
      if (!grab_active) begin
        skip_q <= '0;
      end
      unique case (state_q)
        StIdle: begin
          if ((host_req || seq_req) && !spi_busy) begin
            spi_wr       <= grant_seq ? seq_wr    : host_wr;
            spi_addr     <= grant_seq ? seq_addr  : host_addr;
            spi_wdata    <= grant_seq ? seq_wdata : host_wdata;
            owner        <= grant_seq;
            last_owner_q <= grant_seq;
            // Start and ack are registered so they appear during ISSUE.
            spi_start    <= 1'b1;
            host_ack     <= ~grant_seq;
            seq_ack      <= grant_seq;
            if (!grant_seq) begin
              skip_q <= '0;
            end else if (contested && grab_active) begin
              skip_q <= skip_q + 1'b1;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (spi_done || (timer_q == TimerLast)) begin
            if (owner) begin
              seq_done  <= 1'b1;
              seq_rdata <= rsp_data;
              seq_err   <= rsp_err;
            end else begin
              host_done  <= 1'b1;
              host_rdata <= rsp_data;
              host_err   <= rsp_err;
            end
            if (!spi_done && (timeout_cnt != 8'hFF)) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            state_q <= StResp;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgs_spi_arbiter.sv
// Self-checking bench for xgs_spi_arbiter (TIMEOUT = 16). Expected commands and
// responses are queued when stimulus is driven; a negedge monitor pops and compares
// them when spi_start or a done pulse appears. A small SPI-master model answers each
// spi_start after slave_delay WAIT cycles (0 = never answers).
module tb_xgs_spi_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        host_req, host_wr, host_ack, host_done, host_err;
  logic [14:0] host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        seq_req, seq_wr, seq_ack, seq_done, seq_err;
  logic [14:0] seq_addr;
  logic [15:0] seq_wdata, seq_rdata;
  logic        grab_active;
  logic        spi_start, spi_wr, spi_busy, spi_done;
  logic [14:0] spi_addr;
  logic [15:0] spi_wdata, spi_rdata;
  logic        owner;
  logic [7:0]  timeout_cnt;

  xgs_spi_arbiter #(
    .ADDR_W(15), .DATA_W(16), .TIMEOUT(16), .MAX_HOST_SKIP(4)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_done(host_done),
    .host_rdata(host_rdata), .host_err(host_err),
    .seq_req(seq_req), .seq_wr(seq_wr), .seq_addr(seq_addr),
    .seq_wdata(seq_wdata), .seq_ack(seq_ack), .seq_done(seq_done),
    .seq_rdata(seq_rdata), .seq_err(seq_err),
    .grab_active(grab_active),
    .spi_start(spi_start), .spi_wr(spi_wr), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_rdata(spi_rdata), .owner(owner), .timeout_cnt(timeout_cnt)
  );

  initial forever #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        who;    // 0 host, 1 seq
    logic        wr;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          lat;    // posedges from spi_start cycle to done cycle
  } exp_t;

  typedef struct {
    logic        who;
    logic        grab;
    logic        wr;
    logic [14:0] addr;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] srd;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  exp_t cmd_q[$];
  exp_t resp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   slave_delay = 0;
  logic [15:0] slave_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  function automatic logic any_out();
    return |{host_ack, host_done, host_rdata, host_err, seq_ack, seq_done, seq_rdata,
             seq_err, spi_start, spi_wr, spi_addr, spi_wdata, owner, timeout_cnt};
  endfunction

  task automatic push(input logic who, input logic wr, input logic [14:0] a,
                      input logic [15:0] d, input logic [15:0] rd, input logic err,
                      input int lat, input bit with_resp);
    exp_t e;
    e = '{who, wr, a, d, rd, err, lat};
    cmd_q.push_back(e);
    if (with_resp) resp_q.push_back(e);
  endtask

  task automatic host_xact(input logic wr, input logic [14:0] a, input logic [15:0] d);
    host_wr = wr; host_addr = a; host_wdata = d; host_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (host_ack) break;
    end
    check("host_ack_seen", host_ack, 1);
    @(posedge sys_clk); #1;
    host_req = 1'b0;
  endtask

  task automatic seq_xact(input logic wr, input logic [14:0] a, input logic [15:0] d);
    seq_wr = wr; seq_addr = a; seq_wdata = d; seq_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (seq_ack) break;
    end
    check("seq_ack_seen", seq_ack, 1);
    @(posedge sys_clk); #1;
    seq_req = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd_q.size() == 0 && resp_q.size() == 0) break;
      @(negedge sys_clk);
    end
    check("drain", cmd_q.size() + resp_q.size(), 0);
    cmd_q.delete();
    resp_q.delete();
    @(posedge sys_clk); #1;
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // SPI master model.
  initial begin
    spi_done  = 1'b0;
    spi_rdata = '0;
    forever begin
      @(negedge sys_clk);
      if (spi_start === 1'b1 && slave_delay > 0 && !sys_reset) begin
        @(posedge sys_clk);
        repeat (slave_delay - 1) @(posedge sys_clk);
        #1;
        spi_done  = 1'b1;
        spi_rdata = slave_rdata;
        @(posedge sys_clk); #1;
        spi_done  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_reset) begin
        if (spi_start) begin
          if (cmd_q.size() == 0) begin
            check("unexpected_start", spi_start, 0);
          end else begin
            e = cmd_q.pop_front();
            check("start_owner", owner, e.who);
            check("spi_wr", spi_wr, e.wr);
            check("spi_addr", spi_addr, e.addr);
            check("spi_wdata", spi_wdata, e.wdata);
            check("ack_host", host_ack, !e.who);
            check("ack_seq", seq_ack, e.who);
            start_cyc = cyc;
          end
        end else if (host_ack || seq_ack) begin
          check("ack_without_start", {host_ack, seq_ack}, 0);
        end
        if (host_done || seq_done) begin
          if (resp_q.size() == 0) begin
            check("unexpected_done", {host_done, seq_done}, 0);
          end else begin
            e = resp_q.pop_front();
            check("done_host", host_done, !e.who);
            check("done_seq", seq_done, e.who);
            check("rdata", e.who ? seq_rdata : host_rdata, e.rdata);
            check("err", e.who ? seq_err : host_err, e.err);
            check("latency", cyc - start_cyc, e.lat);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b1, 1'b0, 1'b0, 15'h7FFF, 16'h0000, 1,  16'hBEEF, 16'hBEEF, 2};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 15'h0001, 16'hA5A5, 2,  16'hFFFF, 16'h0000, 3};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 15'h1234, 16'h5A5A, 5,  16'h1111, 16'h0000, 6};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 15'h4000, 16'h0000, 16, 16'hC0DE, 16'hC0DE, 17};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 15'h0000, 16'h0000, 1,  16'hFFFF, 16'hFFFF, 2};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 15'h2AAA, 16'h0000, 2,  16'h0F0F, 16'h0F0F, 3};

    sys_reset = 1'b1;
    host_req = 0; host_wr = 0; host_addr = '0; host_wdata = '0;
    seq_req = 0; seq_wr = 0; seq_addr = '0; seq_wdata = '0;
    grab_active = 0; spi_busy = 0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_outs_zero", any_out(), 0);
    @(posedge sys_clk); #1;
    sys_reset = 1'b0;

    // Simultaneous writes after reset: host first, then seq.
    slave_delay = 1;
    push(1'b0, 1'b1, 15'h011, 16'hAAAA, 16'h0000, 1'b0, 2, 1'b1);
    push(1'b1, 1'b1, 15'h022, 16'hBBBB, 16'h0000, 1'b0, 2, 1'b1);
    fork
      host_xact(1'b1, 15'h011, 16'hAAAA);
      seq_xact(1'b1, 15'h022, 16'hBBBB);
    join
    wait_drain(60);

    // Host read 0x0A5, answered in the third WAIT cycle.
    slave_delay = 3; slave_rdata = 16'h1234;
    push(1'b0, 1'b0, 15'h0A5, 16'h0000, 16'h1234, 1'b0, 4, 1'b1);
    host_wr = 0; host_addr = 15'h0A5; host_wdata = '0; host_req = 1'b1;
    @(negedge sys_clk);
    check("req_cycle_no_start", spi_start, 0);
    @(negedge sys_clk);
    check("start_after_1cyc", spi_start, 1);
    check("ack_with_start", host_ack, 1);
    @(posedge sys_clk); #1;
    host_req = 1'b0;
    wait_drain(60);

    // Single-requester vectors.
    for (int i = 0; i < 6; i++) begin
      grab_active = vecs[i].grab;
      slave_delay = vecs[i].delay;
      slave_rdata = vecs[i].srd;
      push(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0,
           vecs[i].exp_lat, 1'b1);
      if (vecs[i].who) seq_xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      else host_xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_drain(60);
    end
    check("host_rdata_hold", host_rdata, 16'hFFFF);
    check("seq_rdata_hold", seq_rdata, 16'h0F0F);
    check("errs_clear", {host_err, seq_err}, 0);
    check("no_timeout_at_limit", timeout_cnt, 0);

    // Grab mode, both requesting continuously: seq x4, host x1, repeated.
    grab_active = 1'b1;
    slave_delay = 1;
    host_wr = 1; host_addr = 15'h100; host_wdata = 16'h1111;
    seq_wr = 1; seq_addr = 15'h200; seq_wdata = 16'h2222;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(1'b1, 1'b1, 15'h200, 16'h2222, 16'h0, 1'b0, 2, 1'b1);
      push(1'b0, 1'b1, 15'h100, 16'h1111, 16'h0, 1'b0, 2, 1'b1);
    end
    host_req = 1'b1; seq_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (cmd_q.size() == 0) break;
      @(negedge sys_clk);
    end
    @(posedge sys_clk); #1;
    host_req = 1'b0; seq_req = 1'b0;
    wait_drain(60);
    grab_active = 1'b0;

    // Busy master holds off the grant until the cycle after busy falls.
    slave_delay = 1; slave_rdata = 16'h4321;
    push(1'b0, 1'b0, 15'h055, 16'h0000, 16'h4321, 1'b0, 2, 1'b1);
    spi_busy = 1'b1;
    host_wr = 0; host_addr = 15'h055; host_wdata = '0; host_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("busy_no_grant", {spi_start, host_ack}, 0);
    end
    @(posedge sys_clk); #1;
    spi_busy = 1'b0;
    @(negedge sys_clk);
    check("busy_fall_cycle", spi_start, 0);
    @(negedge sys_clk);
    check("grant_after_busy", spi_start, 1);
    @(posedge sys_clk); #1;
    host_req = 1'b0;
    wait_drain(60);

    // spi_done never arrives: abort after 16 WAIT cycles.
    slave_delay = 0;
    push(1'b0, 1'b0, 15'h033, 16'h0000, 16'h0000, 1'b1, 17, 1'b1);
    host_xact(1'b0, 15'h033, 16'h0000);
    wait_drain(60);
    check("timeout_cnt", timeout_cnt, 1);

    // Reset while in WAIT, late spi_done afterwards.
    push(1'b0, 1'b0, 15'h066, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);
    host_xact(1'b0, 15'h066, 16'h0000);
    sys_reset = 1'b1;
    @(posedge sys_clk); #1;
    sys_reset = 1'b0;
    @(negedge sys_clk);
    check("mid_reset_outs_zero", any_out(), 0);
    @(posedge sys_clk); #1;
    spi_done = 1'b1; spi_rdata = 16'hDEAD;
    @(negedge sys_clk);
    check("late_done_outs_zero", any_out(), 0);
    @(posedge sys_clk); #1;
    spi_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      check("after_late_done_zero", any_out(), 0);
    end
    cmd_q.delete();
    @(posedge sys_clk); #1;

    // After reset the host again wins the first tie.
    slave_delay = 1; slave_rdata = 16'h0;
    push(1'b0, 1'b1, 15'h7FF, 16'h1357, 16'h0000, 1'b0, 2, 1'b1);
    push(1'b1, 1'b0, 15'h0F0, 16'h0000, 16'h0000, 1'b0, 2, 1'b1);
    fork
      host_xact(1'b1, 15'h7FF, 16'h1357);
      seq_xact(1'b0, 15'h0F0, 16'h0000);
    join
    wait_drain(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
